// File: rtl/qdr_port_arbiter_pkg.sv
// Shared definitions for the two-port QDRII+ MIG arbiter: default widths,
// the requester port ID type and the round-robin pick helper.
package qdr_arb_pkg;

  localparam int DEF_ADDR_W    = 19;   // qdriip_sa burst address
  localparam int DEF_DATA_W    = 144;  // 4 beats x 36 bits
  localparam int DEF_BW_W      = 16;   // 4 beats x 4 byte-write enables
  localparam int DEF_TAG_DEPTH = 32;   // outstanding reads, power of two

  // Idle level of one active-low byte-write enable.
  localparam logic BW_N_IDLE = 1'b1;

  // Requester port ID: 0 = ETH0 path, 1 = ETH1 path.
  typedef logic port_id_t;

  // Round-robin pick: the pointer port wins if it requests, otherwise the other port.
  function automatic port_id_t rr_pick(input port_id_t ptr, input logic [1:0] valid);
    return valid[ptr] ? ptr : ~ptr;
  endfunction

endpackage

// File: rtl/qdr_port_arbiter_if.sv
// Requester-side bundle of the arbiter: per-port write, read and response
// channels. The arbiter uses the slave view, requesters the master view.
interface qdr_port_arbiter_if
  import qdr_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BW_W   = DEF_BW_W
) ();

  logic [1:0]        wr_valid;
  logic [1:0]        wr_ready;
  logic [ADDR_W-1:0] wr_addr  [2];
  logic [DATA_W-1:0] wr_data  [2];
  logic [BW_W-1:0]   wr_bw_n  [2];

  logic [1:0]        rd_valid;
  logic [1:0]        rd_ready;
  logic [ADDR_W-1:0] rd_addr  [2];

  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data [2];

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_bw_n, rd_valid, rd_addr,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_bw_n, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/qdr_port_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit port IDs, one entry per outstanding MIG read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module qdr_tag_fifo
  import qdr_arb_pkg::*;
#(
  parameter  int DEPTH = DEF_TAG_DEPTH,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  port_id_t         i_push_id,
  input  logic             i_pop,
  output port_id_t         o_head_id,
  output logic [PTR_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int IDX_W = PTR_W - 1;

  port_id_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign o_head_id = r_mem[r_rd_ptr[IDX_W-1:0]];

  // Tag storage write.
  // NOTE: the storage array has no reset; an entry is only read after it was
  // written, and the pointers (which are reset) define which entries are live.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_id;
  end

  // Read/write pointers; wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/qdr_port_arbiter.sv
// Shares one QDRII+ MIG user interface (burst-4, slot 0) between two
// requesters. Write and read channels have independent round-robin arbiters;
// read responses are steered back to the issuing port through the tag FIFO.
module qdr_port_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BW_W      = DEF_BW_W,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              init_calib_complete,
  qdr_port_arbiter_if.slave port_if,
  output logic              app_wr_cmd0,
  output logic [ADDR_W-1:0] app_wr_addr0,
  output logic [DATA_W-1:0] app_wr_data0,
  output logic [BW_W-1:0]   app_wr_bw_n0,
  output logic              app_rd_cmd0,
  output logic [ADDR_W-1:0] app_rd_addr0,
  input  logic              app_rd_valid0,
  input  logic [DATA_W-1:0] app_rd_data0,
  output logic              tag_err
);

  localparam int               PTR_W     = $clog2(TAG_DEPTH) + 1;
  localparam logic [PTR_W-1:0] TAG_LIMIT = PTR_W'(TAG_DEPTH);

  port_id_t          r_wr_ptr, r_rd_ptr;
  logic              r_app_wr_cmd, r_app_rd_cmd, r_tag_err;
  logic [ADDR_W-1:0] r_app_wr_addr, r_app_rd_addr;
  logic [DATA_W-1:0] r_app_wr_data;
  logic [BW_W-1:0]   r_app_wr_bw_n;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data [2];

  port_id_t          w_wr_gnt, w_rd_gnt, w_tag_head;
  logic              w_wr_acc, w_rd_acc, w_rd_room, w_rsp_pop;
  logic [1:0]        w_wr_ready, w_rd_ready;
  logic [PTR_W-1:0]  w_tag_count;
  logic              w_tag_full, w_tag_empty;

  // Read room uses the count before any same-cycle pop: no pop-to-push bypass.
  assign w_rd_room = (w_tag_count < TAG_LIMIT);
  assign w_rsp_pop = app_rd_valid0 & ~w_tag_empty;

  // Round-robin grant and accept for both channels, gated by calibration.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_wr_ready = '0;
    w_rd_ready = '0;
    w_wr_gnt   = rr_pick(r_wr_ptr, port_if.wr_valid);
    w_rd_gnt   = rr_pick(r_rd_ptr, port_if.rd_valid);
    w_wr_acc   = init_calib_complete & port_if.wr_valid[w_wr_gnt];
    w_rd_acc   = init_calib_complete & port_if.rd_valid[w_rd_gnt] & w_rd_room;
    w_wr_ready[w_wr_gnt] = w_wr_acc;
    w_rd_ready[w_rd_gnt] = w_rd_acc;
  end

  // Write channel: pointer advance and the registered MIG write command.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr      <= 1'b0;
      r_app_wr_cmd  <= 1'b0;
      r_app_wr_addr <= '0;
      r_app_wr_data <= '0;
      r_app_wr_bw_n <= {BW_W{BW_N_IDLE}};
    end else begin
      r_app_wr_cmd <= w_wr_acc;
      if (w_wr_acc) begin
        r_wr_ptr      <= ~w_wr_gnt;
        r_app_wr_addr <= port_if.wr_addr[w_wr_gnt];
        r_app_wr_data <= port_if.wr_data[w_wr_gnt];
        r_app_wr_bw_n <= port_if.wr_bw_n[w_wr_gnt];
      end
    end
  end

  // Read channel: pointer advance and the registered MIG read command.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_ptr      <= 1'b0;
      r_app_rd_cmd  <= 1'b0;
      r_app_rd_addr <= '0;
    end else begin
      r_app_rd_cmd <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_ptr      <= ~w_rd_gnt;
        r_app_rd_addr <= port_if.rd_addr[w_rd_gnt];
      end
    end
  end

  // Response steering to the head-tag port; orphan read data sets tag_err.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rsp_valid   <= '0;
      r_rsp_data[0] <= '0;
      r_rsp_data[1] <= '0;
      r_tag_err     <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_rsp_pop) begin
        r_rsp_valid[w_tag_head] <= 1'b1;
        r_rsp_data[w_tag_head]  <= app_rd_data0;
      end
      if (app_rd_valid0 && w_tag_empty) r_tag_err <= 1'b1;
    end
  end

  qdr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .i_push    (w_rd_acc),
    .i_push_id (w_rd_gnt),
    .i_pop     (w_rsp_pop),
    .o_head_id (w_tag_head),
    .o_count   (w_tag_count),
    .o_full    (w_tag_full),
    .o_empty   (w_tag_empty)
  );

  // The FIFO's full flag and its count must always tell the same story.
  a_full_matches_count: assert property (@(posedge clk) disable iff (!sys_rst_n)
    w_tag_full == (w_tag_count == TAG_LIMIT));

  assign port_if.wr_ready    = w_wr_ready;
  assign port_if.rd_ready    = w_rd_ready;
  assign port_if.rsp_valid   = r_rsp_valid;
  assign port_if.rsp_data[0] = r_rsp_data[0];
  assign port_if.rsp_data[1] = r_rsp_data[1];
  assign app_wr_cmd0         = r_app_wr_cmd;
  assign app_wr_addr0        = r_app_wr_addr;
  assign app_wr_data0        = r_app_wr_data;
  assign app_wr_bw_n0        = r_app_wr_bw_n;
  assign app_rd_cmd0         = r_app_rd_cmd;
  assign app_rd_addr0        = r_app_rd_addr;
  assign tag_err             = r_tag_err;

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// Bench for qdr_port_arbiter: directed scenarios plus a randomized phase, a
// transaction-level reference model (queue of outstanding read tags) checked
// every cycle, and a simple in-order MIG read responder.
module tb_qdr_port_arbiter;
  import qdr_arb_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int BW = DEF_BW_W;
  localparam int TD = DEF_TAG_DEPTH;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          init_calib_complete = 1'b0;
  logic          app_wr_cmd0, app_rd_cmd0, tag_err;
  logic [AW-1:0] app_wr_addr0, app_rd_addr0;
  logic [DW-1:0] app_wr_data0;
  logic [BW-1:0] app_wr_bw_n0;
  logic          app_rd_valid0 = 1'b0;
  logic [DW-1:0] app_rd_data0 = '0;

  qdr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BW_W(BW)) pif ();

  qdr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BW_W(BW), .TAG_DEPTH(TD)) dut (
    .clk                 (clk),
    .sys_rst_n           (sys_rst_n),
    .init_calib_complete (init_calib_complete),
    .port_if             (pif),
    .app_wr_cmd0         (app_wr_cmd0),
    .app_wr_addr0        (app_wr_addr0),
    .app_wr_data0        (app_wr_data0),
    .app_wr_bw_n0        (app_wr_bw_n0),
    .app_rd_cmd0         (app_rd_cmd0),
    .app_rd_addr0        (app_rd_addr0),
    .app_rd_valid0       (app_rd_valid0),
    .app_rd_data0        (app_rd_data0),
    .tag_err             (tag_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return {16'hD0D0, 109'd0, a};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  // ---------------- MIG read responder (in order, fixed latency) ----------
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } mig_t;

  mig_t mig_q[$];
  int   cyc        = 0;
  int   mig_lat    = 10;
  bit   mig_en     = 1'b1;
  bit   inject_req = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!sys_rst_n) mig_q.delete();
    else if (app_rd_cmd0) mig_q.push_back('{cyc + mig_lat, app_rd_addr0});
  end

  always @(posedge clk) begin
    mig_t m;
    #1;
    app_rd_valid0 = 1'b0;
    if (sys_rst_n) begin
      if (inject_req) begin
        app_rd_valid0 = 1'b1;
        app_rd_data0  = mk_data(19'h7FFFF);
        inject_req    = 1'b0;
      end else if (mig_en && mig_q.size() > 0 && mig_q[0].due <= cyc) begin
        m = mig_q.pop_front();
        app_rd_valid0 = 1'b1;
        app_rd_data0  = mk_data(m.addr);
      end
    end
  end

  // ---------------- reference model ---------------------------------------
  int            m_wr_ptr, m_rd_ptr;
  bit            m_tags[$];
  logic          e_wr_cmd, e_rd_cmd, e_tag_err;
  logic [AW-1:0] e_wr_addr, e_rd_addr;
  logic [DW-1:0] e_wr_data;
  logic [BW-1:0] e_wr_bw;
  logic [1:0]    e_rsp_valid;
  logic [DW-1:0] e_rsp_data [2];

  task automatic model_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_tags.delete();
    e_wr_cmd = 0; e_rd_cmd = 0; e_tag_err = 0;
    e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_wr_bw = '1;
    e_rsp_valid = '0; e_rsp_data[0] = '0; e_rsp_data[1] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " app_wr_cmd0"},  app_wr_cmd0, 0);
    check({tag, " app_wr_addr0"}, app_wr_addr0, 0);
    check({tag, " app_wr_data0"}, app_wr_data0, 0);
    check({tag, " app_wr_bw_n0"}, app_wr_bw_n0, DW'({BW{1'b1}}));
    check({tag, " app_rd_cmd0"},  app_rd_cmd0, 0);
    check({tag, " app_rd_addr0"}, app_rd_addr0, 0);
    check({tag, " rsp_valid"},    pif.rsp_valid, 0);
    check({tag, " rsp_data0"},    pif.rsp_data[0], 0);
    check({tag, " rsp_data1"},    pif.rsp_data[1], 0);
    check({tag, " tag_err"},      tag_err, 0);
  endtask

  task automatic compare_regs();
    check("app_wr_cmd0", app_wr_cmd0, e_wr_cmd);
    if (e_wr_cmd) begin
      check("app_wr_addr0", app_wr_addr0, e_wr_addr);
      check("app_wr_data0", app_wr_data0, e_wr_data);
      check("app_wr_bw_n0", app_wr_bw_n0, e_wr_bw);
    end
    check("app_rd_cmd0", app_rd_cmd0, e_rd_cmd);
    if (e_rd_cmd) check("app_rd_addr0", app_rd_addr0, e_rd_addr);
    check("rsp_valid", pif.rsp_valid, e_rsp_valid);
    for (int p = 0; p < 2; p++)
      if (e_rsp_valid[p]) check($sformatf("rsp_data%0d", p), pif.rsp_data[p], e_rsp_data[p]);
    check("tag_err", tag_err, e_tag_err);
  endtask

  // Evaluate this cycle's arbitration from the rules, check the readies, then
  // advance the model to what the registers must hold after the next edge.
  task automatic model_step();
    int         gw, gr;
    bit         wacc, racc, t;
    logic [1:0] ew, er;
    gw   = pif.wr_valid[m_wr_ptr] ? m_wr_ptr : 1 - m_wr_ptr;
    gr   = pif.rd_valid[m_rd_ptr] ? m_rd_ptr : 1 - m_rd_ptr;
    wacc = init_calib_complete && pif.wr_valid[gw];
    racc = init_calib_complete && pif.rd_valid[gr] && (m_tags.size() < TD);
    ew = '0; if (wacc) ew[gw] = 1'b1;
    er = '0; if (racc) er[gr] = 1'b1;
    check("wr_ready", pif.wr_ready, ew);
    check("rd_ready", pif.rd_ready, er);
    e_wr_cmd = wacc;
    if (wacc) begin
      e_wr_addr = pif.wr_addr[gw];
      e_wr_data = pif.wr_data[gw];
      e_wr_bw   = pif.wr_bw_n[gw];
      m_wr_ptr  = 1 - gw;
    end
    e_rd_cmd = racc;
    if (racc) begin
      e_rd_addr = pif.rd_addr[gr];
      m_rd_ptr  = 1 - gr;
    end
    e_rsp_valid = '0;
    if (app_rd_valid0) begin
      if (m_tags.size() == 0) e_tag_err = 1'b1;
      else begin
        t = m_tags.pop_front();
        e_rsp_valid[t] = 1'b1;
        e_rsp_data[t]  = app_rd_data0;
      end
    end
    if (racc) m_tags.push_back(gr[0]);
  endtask

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      model_reset();
      check_reset_outputs("in reset");
    end else begin
      compare_regs();
      model_step();
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output logic [1:0] v, output logic [DW-1:0] d, output bit ok);
    ok = 0; v = '0; d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pif.rsp_valid != 2'b00) begin
        v  = pif.rsp_valid;
        d  = pif.rsp_valid[1] ? pif.rsp_data[1] : pif.rsp_data[0];
        ok = 1;
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mig_q.size() == 0 && m_tags.size() == 0 && pif.rsp_valid == 2'b00) begin
        ok = 1;
        break;
      end
    end
    check({nm, " drained"}, ok, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------------------------------------
  initial begin
    logic [1:0]    v;
    logic [DW-1:0] d;
    bit            ok;
    int            acc, rsp_cnt;

    pif.wr_valid = '0; pif.rd_valid = '0;
    for (int p = 0; p < 2; p++) begin
      pif.wr_addr[p] = '0; pif.wr_data[p] = '0; pif.wr_bw_n[p] = '1; pif.rd_addr[p] = '0;
    end

    repeat (3) tick();
    check_reset_outputs("initial reset");
    sys_rst_n = 1'b1;

    // 1: calibration gate, then port 0 wins first.
    pif.wr_valid = 2'b11; pif.rd_valid = 2'b11;
    pif.wr_addr[0] = 19'h00100; pif.wr_addr[1] = 19'h00200;
    pif.rd_addr[0] = 19'h00300; pif.rd_addr[1] = 19'h00400;
    pif.wr_data[0] = rnd_data(); pif.wr_data[1] = rnd_data();
    repeat (4) begin
      @(negedge clk);
      check("t1 wr_ready gated", pif.wr_ready, 0);
      check("t1 rd_ready gated", pif.rd_ready, 0);
      check("t1 wr_cmd gated", app_wr_cmd0, 0);
      check("t1 rd_cmd gated", app_rd_cmd0, 0);
    end
    tick();
    init_calib_complete = 1'b1;
    @(negedge clk);
    check("t1 wr first grant", pif.wr_ready, 2'b01);
    check("t1 rd first grant", pif.rd_ready, 2'b01);
    @(negedge clk);
    check("t1 wr_cmd", app_wr_cmd0, 1);
    check("t1 wr_addr", app_wr_addr0, 19'h00100);
    check("t1 rd_addr", app_rd_addr0, 19'h00300);
    check("t1 wr second grant", pif.wr_ready, 2'b10);
    tick();
    pif.wr_valid = '0; pif.rd_valid = '0;
    do_reset();

    // 2: both ports hold wr_valid for six cycles.
    pif.wr_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) check($sformatf("t2 grant %0d", i), pif.wr_ready, (i % 2) ? 2'b10 : 2'b01);
      if (i == 6) check("t2 ready after stop", pif.wr_ready, 0);
      if (i >= 1 && i <= 6) begin
        check($sformatf("t2 cmd %0d", i), app_wr_cmd0, 1);
        check($sformatf("t2 addr %0d", i), app_wr_addr0, ((i - 1) % 2) ? 19'h00200 : 19'h00100);
      end
      if (i == 7) check("t2 cmd off", app_wr_cmd0, 0);
      if (i == 5) begin
        tick();
        pif.wr_valid = '0;
      end
    end

    // 3: port 1 reads A, port 0 reads B; responses routed in order.
    tick();
    pif.rd_addr[1] = 19'h00010; pif.rd_valid = 2'b10;
    tick();
    pif.rd_addr[0] = 19'h00020; pif.rd_valid = 2'b01;
    tick();
    pif.rd_valid = '0;
    wait_rsp(v, d, ok);
    check("t3 rsp1 seen", ok, 1);
    check("t3 rsp1 port", v, 2'b10);
    check("t3 rsp1 data", d, {16'hD0D0, 109'd0, 19'h00010});
    wait_rsp(v, d, ok);
    check("t3 rsp2 seen", ok, 1);
    check("t3 rsp2 port", v, 2'b01);
    check("t3 rsp2 data", d, {16'hD0D0, 109'd0, 19'h00020});
    drain("t3");

    // 4: fill the tag FIFO with a stalled MIG.
    mig_en = 1'b0;
    tick();
    pif.rd_addr[0] = 19'h00040; pif.rd_valid = 2'b01;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pif.rd_ready[0]) acc++;
    end
    check("t4 accepts until full", acc, TD);
    check("t4 read 33 blocked", pif.rd_ready, 0);
    mig_en = 1'b1;
    @(negedge clk);
    check("t4 blocked on pop cycle", pif.rd_ready, 0);
    @(negedge clk);
    check("t4 ready after pop", pif.rd_ready, 2'b01);
    repeat (20) @(negedge clk);
    tick();
    pif.rd_valid = '0;
    drain("t4");

    // 5: orphan read data.
    inject_req = 1'b1;
    @(negedge clk);
    check("t5 tag_err before", tag_err, 0);
    @(negedge clk);
    check("t5 no rsp", pif.rsp_valid, 0);
    check("t5 tag_err set", tag_err, 1);
    repeat (5) @(negedge clk);
    check("t5 tag_err sticky", tag_err, 1);

    // Randomized traffic, calibration drops and MIG stalls.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mig_en  = ($urandom_range(0, 3) != 0);
      mig_lat = $urandom_range(3, 14);
      tick();
      init_calib_complete = ($urandom_range(0, 19) != 0);
      pif.wr_valid = 2'($urandom);
      pif.rd_valid = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        pif.wr_addr[p] = AW'($urandom);
        pif.wr_data[p] = rnd_data();
        pif.wr_bw_n[p] = BW'($urandom);
        pif.rd_addr[p] = AW'($urandom);
      end
    end
    @(negedge clk);
    mig_en = 1'b1; mig_lat = 10;
    tick();
    pif.wr_valid = '0; pif.rd_valid = '0; init_calib_complete = 1'b1;
    drain("random");

    // 6: reset with five reads outstanding.
    do_reset();
    @(negedge clk);
    mig_lat = 40;
    tick();
    pif.rd_valid = 2'b11; pif.wr_valid = 2'b11;
    repeat (5) tick();
    pif.rd_valid = '0;
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6 async reset");
    pif.wr_valid = '0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    @(negedge clk);
    mig_en = 1'b0; mig_lat = 10;
    tick();
    pif.rd_valid = 2'b01;
    acc = 0; rsp_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pif.rd_ready[0]) acc++;
      if (pif.rsp_valid != 2'b00) rsp_cnt++;
    end
    check("t6 full depth after reset", acc, TD);
    check("t6 stale responses", rsp_cnt, 0);
    check("t6 tag_err cleared", tag_err, 0);
    mig_en = 1'b1;
    tick();
    pif.rd_valid = '0;
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
